pong_flow_ctrl: RTL and testbench
=================================

Name: pong_flow_ctrl

Overview:
Parametrised top-level game-flow controller for the Pong family. It sequences START, COUNTDOWN, GAME, PAUSE and END screens for N players. It detects the winner from a flattened score bus and issues a one-cycle active-low game reset to the playfield logic. It replaces the fixed two-player flow FSM and adds an enter edge detector, a tick-driven serve countdown, configurable max score and player count, and winner reporting.

Parameters:
NUM_PLAYERS, 2, number of score channels (2..8)
SCORE_W, 4, width of each player's score
MAX_SCORE, 9, score at or above which a player wins (must fit in SCORE_W)
COUNTDOWN_TICKS, 3, tick strobes counted in COUNTDOWN before play starts (1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
enter  in  1  joystick button, level, already synchronised
tick  in  1  one-cycle strobe (e.g. 1 Hz) for the countdown
menu_sel  in  2  pause-menu choice: 0 resume, 1 restart, 2 quit, 3 none
scores  in  NUM_PLAYERS*SCORE_W  player p score at bits [p*SCORE_W +: SCORE_W]
en_start  out  1  start menu visible
en_countdown  out  1  countdown overlay visible
en_game  out  1  playfield running
en_pause  out  1  pause menu visible
en_end  out  1  end screen visible
game_rst_n  out  1  playfield/score reset, active-low pulse
countdown  out  4  remaining countdown value shown on screen
winner  out  max(1,$clog2(NUM_PLAYERS))  index of winning player
winner_valid  out  1  winner holds a valid index

Behaviour:
- Reset has the decided properties: reset reset, synchronous, active-low; clock clock.
- While reset=0, the following hold on every clock edge:
  - state=START, en_start=1, other enables 0.
  - countdown=0, winner=0, winner_valid=0, game_rst_n=0.
  - enter_q=1, so a button held through reset does not register as a press.
- All outputs are registered. Exactly one en_* is 1 at any time, and it reflects the state register (same-cycle as the state).
- Press detection: press = enter & ~enter_q, with enter_q registered every cycle. Holding enter generates one press only. All transitions below use press, never the enter level.
- game_rst_n: driven 0 for exactly one cycle on the cycle after a "reset game" transition, otherwise 1.
- win = OR over players of (score_p >= MAX_SCORE), unsigned compare. The winner index is the lowest p satisfying it, so simultaneous winners resolve to the lowest index.
- START:
  - press -> COUNTDOWN; load countdown=COUNTDOWN_TICKS; reset game; clear winner_valid.
- COUNTDOWN:
  - press is ignored.
  - A tick with countdown>1 decrements countdown.
  - A tick with countdown==1 sets countdown=0 and moves to GAME.
- GAME, evaluated in priority order:
  - win -> END; latch winner; winner_valid=1. Win beats press in the same cycle.
  - Otherwise press -> PAUSE.
  - Tick is ignored.
- PAUSE, on press:
  - menu_sel=0 -> COUNTDOWN, countdown=COUNTDOWN_TICKS, no game reset.
  - menu_sel=1 -> COUNTDOWN, countdown=COUNTDOWN_TICKS, reset game.
  - menu_sel=2 -> START.
  - menu_sel=3 -> stay in PAUSE.
  - Without a press, stay in PAUSE. Scores are not evaluated in PAUSE.
- END:
  - press -> START. winner and winner_valid hold until the next START->COUNTDOWN transition.
- Illegal state encoding -> START next cycle, with a game reset pulse.
- Tick and press in the same cycle: each is handled per the current state's rules above. Only one transition happens per cycle.
- Reset asserted mid-countdown or mid-game returns to START on that edge. No partial state survives it.

Test Plan:
1. Reset low 3 cycles with enter=1, then release keeping enter=1 -> en_start=1, no transition until enter drops and rises again. First press -> en_countdown=1, countdown=3, game_rst_n=0 for exactly 1 cycle.
2. In COUNTDOWN, pulse tick 3 times with a press between ticks -> countdown 3,2,1, then en_game=1 with countdown=0 on the third tick. The press has no effect.
3. GAME with scores {p1=4,p0=8}, raise p1 to 9 while pressing in the same cycle -> END (not PAUSE), winner=1, winner_valid=1.
4. NUM_PLAYERS=4, MAX_SCORE=5: set p2=5 and p3=7 in the same cycle -> winner=2.
5. PAUSE with menu_sel=3 then press -> stays in PAUSE. menu_sel=0 press -> COUNTDOWN, game_rst_n stays 1. Repeat with menu_sel=1 -> one-cycle game_rst_n=0. menu_sel=2 -> START.
6. Assert reset mid-COUNTDOWN with countdown=2 -> next edge en_start=1, countdown=0, winner_valid=0.

Source files
------------

// File: rtl/pong_flow_ctrl.sv
// Game-flow controller for the Pong family: START/COUNTDOWN/GAME/PAUSE/END
// sequencing, press edge detection, serve countdown and winner reporting.
module pong_flow_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int SCORE_W         = 4,
    parameter int MAX_SCORE       = 9,
    parameter int COUNTDOWN_TICKS = 3,
    localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enter,
    input  logic                           tick,
    input  logic [1:0]                     menu_sel,
    input  logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           en_start,
    output logic                           en_countdown,
    output logic                           en_game,
    output logic                           en_pause,
    output logic                           en_end,
    output logic                           game_rst_n,
    output logic [3:0]                     countdown,
    output logic [WIN_W-1:0]               winner,
    output logic                           winner_valid
);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_GAME      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_END       = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] MAX_SCORE_V = SCORE_W'(MAX_SCORE);
    localparam logic [3:0]         CD_LOAD_V   = 4'(COUNTDOWN_TICKS);

    // True when any player has reached the winning score.
    function automatic logic any_winner(input logic [NUM_PLAYERS*SCORE_W-1:0] sc);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hit = hit | (sc[p*SCORE_W +: SCORE_W] >= MAX_SCORE_V);
        end
        return hit;
    endfunction

    // Scanning downwards lets the lowest winning index overwrite the others.
    function automatic logic [WIN_W-1:0] lowest_winner(input logic [NUM_PLAYERS*SCORE_W-1:0] sc);
        logic [WIN_W-1:0] idx;
        idx = {WIN_W{1'b0}};
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (sc[p*SCORE_W +: SCORE_W] >= MAX_SCORE_V) begin
                idx = WIN_W'(p);
            end
        end
        return idx;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             enter_q_r;
    logic             press_s;
    logic             win_s;
    logic [WIN_W-1:0] win_idx_s;
    logic [3:0]       countdown_r;
    logic [3:0]       countdown_next_s;
    logic [WIN_W-1:0] winner_r;
    logic [WIN_W-1:0] winner_next_s;
    logic             winner_valid_r;
    logic             winner_valid_next_s;
    logic             reset_game_s;
    logic             game_rst_n_r;
    logic             en_start_r;
    logic             en_countdown_r;
    logic             en_game_r;
    logic             en_pause_r;
    logic             en_end_r;

    assign press_s   = enter & ~enter_q_r;
    assign win_s     = any_winner(scores);
    assign win_idx_s = lowest_winner(scores);

    // Next-state, countdown, winner and game-reset decisions.
    always_comb begin
        state_next_s        = state_r;
        countdown_next_s    = countdown_r;
        winner_next_s       = winner_r;
        winner_valid_next_s = winner_valid_r;
        reset_game_s        = 1'b0;
        case (state_r)
            ST_START: begin
                if (press_s) begin
                    state_next_s        = ST_COUNTDOWN;
                    countdown_next_s    = CD_LOAD_V;
                    reset_game_s        = 1'b1;
                    winner_valid_next_s = 1'b0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (countdown_r > 4'd1) begin
                        countdown_next_s = countdown_r - 4'd1;
                    end else begin
                        countdown_next_s = 4'd0;
                        state_next_s     = ST_GAME;
                    end
                end else begin
                    state_next_s = ST_COUNTDOWN;
                end
            end
            ST_GAME: begin
                // A winning score takes precedence over a pause request.
                if (win_s) begin
                    state_next_s        = ST_END;
                    winner_next_s       = win_idx_s;
                    winner_valid_next_s = 1'b1;
                end else if (press_s) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_GAME;
                end
            end
            ST_PAUSE: begin
                if (press_s) begin
                    case (menu_sel)
                        2'd0: begin
                            state_next_s     = ST_COUNTDOWN;
                            countdown_next_s = CD_LOAD_V;
                        end
                        2'd1: begin
                            state_next_s     = ST_COUNTDOWN;
                            countdown_next_s = CD_LOAD_V;
                            reset_game_s     = 1'b1;
                        end
                        2'd2: state_next_s = ST_START;
                        default: state_next_s = ST_PAUSE;
                    endcase
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_END: begin
                if (press_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_END;
                end
            end
            default: begin
                state_next_s = ST_START;
                reset_game_s = 1'b1;
            end
        endcase
    end

    // State and registered outputs; enables are decoded from the same next state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= ST_START;
            enter_q_r      <= 1'b1;
            countdown_r    <= 4'd0;
            winner_r       <= {WIN_W{1'b0}};
            winner_valid_r <= 1'b0;
            game_rst_n_r   <= 1'b0;
            en_start_r     <= 1'b1;
            en_countdown_r <= 1'b0;
            en_game_r      <= 1'b0;
            en_pause_r     <= 1'b0;
            en_end_r       <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            enter_q_r      <= enter;
            countdown_r    <= countdown_next_s;
            winner_r       <= winner_next_s;
            winner_valid_r <= winner_valid_next_s;
            game_rst_n_r   <= ~reset_game_s;
            en_start_r     <= (state_next_s == ST_START);
            en_countdown_r <= (state_next_s == ST_COUNTDOWN);
            en_game_r      <= (state_next_s == ST_GAME);
            en_pause_r     <= (state_next_s == ST_PAUSE);
            en_end_r       <= (state_next_s == ST_END);
        end
    end

    assign en_start     = en_start_r;
    assign en_countdown = en_countdown_r;
    assign en_game      = en_game_r;
    assign en_pause     = en_pause_r;
    assign en_end       = en_end_r;
    assign game_rst_n   = game_rst_n_r;
    assign countdown    = countdown_r;
    assign winner       = winner_r;
    assign winner_valid = winner_valid_r;

endmodule

// File: tb/tb_pong_flow_ctrl.sv
// Scoreboard bench for pong_flow_ctrl: a screen-level reference model predicts
// each cycle's outputs, and a negedge monitor pops and compares them.
module tb_pong_flow_ctrl;

    localparam int NP = 4;
    localparam int SW = 4;
    localparam int MAXS = 5;
    localparam int TICKS = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enter = 1'b0;
    logic          tick = 1'b0;
    logic [1:0]    menu_sel = 2'd3;
    logic [NP*SW-1:0] scores = '0;
    logic          en_start, en_countdown, en_game, en_pause, en_end;
    logic          game_rst_n, winner_valid;
    logic [3:0]    countdown;
    logic [1:0]    winner;

    pong_flow_ctrl #(.NUM_PLAYERS(NP), .SCORE_W(SW), .MAX_SCORE(MAXS), .COUNTDOWN_TICKS(TICKS)) dut (
        .clock(clock), .reset(reset), .enter(enter), .tick(tick), .menu_sel(menu_sel),
        .scores(scores), .en_start(en_start), .en_countdown(en_countdown), .en_game(en_game),
        .en_pause(en_pause), .en_end(en_end), .game_rst_n(game_rst_n), .countdown(countdown),
        .winner(winner), .winner_valid(winner_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] en;
        int         cd;
        logic       grn;
        logic       wv;
        int         win;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: screen index 0..4 = start, countdown, game, pause, end.
    int   m_screen = 0;
    int   m_cd = 0;
    int   m_win = 0;
    bit   m_wv = 0;
    bit   m_grn = 0;
    bit   m_prev_enter = 1;

    function automatic int score_of(int p);
        logic [NP*SW-1:0] s;
        s = scores;
        return int'(s[p*SW +: SW]);
    endfunction

    task automatic model_step();
        bit pressed;
        bit new_game;
        int first;
        if (!reset) begin
            m_screen = 0; m_cd = 0; m_win = 0; m_wv = 0; m_grn = 0; m_prev_enter = 1;
            return;
        end
        pressed = enter && !m_prev_enter;
        m_prev_enter = enter;
        new_game = 0;
        if (m_screen == 0 && pressed) begin
            m_screen = 1; m_cd = TICKS; new_game = 1; m_wv = 0;
        end else if (m_screen == 1 && tick) begin
            m_cd = (m_cd > 1) ? m_cd - 1 : 0;
            if (m_cd == 0) m_screen = 2;
        end else if (m_screen == 2) begin
            first = -1;
            for (int p = 0; p < NP; p++)
                if (first < 0 && score_of(p) >= MAXS) first = p;
            if (first >= 0) begin
                m_screen = 4; m_win = first; m_wv = 1;
            end else if (pressed) m_screen = 3;
        end else if (m_screen == 3 && pressed) begin
            if (menu_sel == 2'd0 || menu_sel == 2'd1) begin
                m_screen = 1; m_cd = TICKS; new_game = (menu_sel == 2'd1);
            end else if (menu_sel == 2'd2) m_screen = 0;
        end else if (m_screen == 4 && pressed) begin
            m_screen = 0;
        end
        m_grn = !new_game;
    endtask

    // Apply current inputs for one clock, queueing what the DUT must show after it.
    task automatic cyc();
        exp_t e;
        model_step();
        e.en = 5'(1 << m_screen);
        e.cd = m_cd; e.grn = m_grn; e.wv = m_wv; e.win = m_win;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic press();
        enter = 1'b1; cyc();
        enter = 1'b0; cyc();
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare against the queue head.
    always @(negedge clock) begin
        exp_t e;
        logic [4:0] en_v;
        if (q.size() > 0) begin
            e = q.pop_front();
            en_v = {en_end, en_pause, en_game, en_countdown, en_start};
            chk("enables", int'(en_v), int'(e.en));
            chk("onehot", int'($onehot(en_v)), 1);
            chk("countdown", int'(countdown), e.cd);
            chk("game_rst_n", int'(game_rst_n), int'(e.grn));
            chk("winner_valid", int'(winner_valid), int'(e.wv));
            if (e.wv) chk("winner", int'(winner), e.win);
        end
    end

    task automatic go_game();
        press();
        repeat (TICKS) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
    endtask

    initial begin
        // Reset with the button held, then release still held: no press expected.
        reset = 1'b0; enter = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        repeat (3) cyc();
        enter = 1'b0; cyc();
        press();
        // Countdown with presses interleaved between ticks.
        repeat (TICKS) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            press();
        end
        // Win beats press in the same cycle.
        scores = {4'd0, 4'd0, 4'd4, 4'd4}; cyc();
        scores = {4'd0, 4'd0, 4'd5, 4'd4}; enter = 1'b1; cyc(); enter = 1'b0; cyc();
        scores = '0; press();
        // Simultaneous winners resolve to the lowest index.
        go_game();
        scores = {4'd7, 4'd5, 4'd0, 4'd0}; cyc();
        scores = '0; press();
        // Pause menu choices.
        go_game();
        press();
        menu_sel = 2'd3; press();
        menu_sel = 2'd0; press();
        repeat (TICKS) begin tick = 1'b1; cyc(); end
        tick = 1'b0;
        press();
        menu_sel = 2'd1; press();
        repeat (TICKS) begin tick = 1'b1; cyc(); end
        tick = 1'b0;
        press();
        menu_sel = 2'd2; press();
        // Reset in the middle of a countdown.
        press();
        tick = 1'b1; cyc(); tick = 1'b0;
        reset = 1'b0; cyc(); reset = 1'b1; cyc();
        // Randomised play.
        for (int n = 0; n < 4000; n++) begin
            logic [NP*SW-1:0] s;
            if ($urandom_range(0, 2) == 0) enter = ~enter;
            tick = ($urandom_range(0, 3) == 0);
            menu_sel = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 399) != 0);
            for (int p = 0; p < NP; p++)
                s[p*SW +: SW] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(MAXS, 15))
                                                              : 4'($urandom_range(0, MAXS - 1));
            scores = s;
            cyc();
        end
        repeat (2) @(posedge clock);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
